// File: rtl/phase_scheduler_pkg.sv
// Shared definitions for the intersection phase scheduler.
// Contains the one-hot FSM state codes and the 3-bit lamp codes
// (G/R/Y order within each approach's lamp field).
package phase_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_GREEN   = 3'b001,
        ST_YELLOW  = 3'b010,
        ST_ALL_RED = 3'b100
    } state_t;

    localparam logic [2:0] LAMP_GREEN  = 3'b100;
    localparam logic [2:0] LAMP_RED    = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

endpackage

// File: rtl/phase_scheduler_rr_picker.sv
// Combinational round-robin selector.
// Ports:
//   pend      in   N_PHASES    request/pending vector
//   last      in   PHASE_BITS  index that last owned the grant
//   next_idx  out  PHASE_BITS  first set index after last (wrapping); last if none
//   valid     out  1           high when any bit of pend is set
module rr_picker #(
    parameter int N_PHASES   = 4,
    parameter int PHASE_BITS = 2
) (
    input  logic [N_PHASES-1:0]   pend,
    input  logic [PHASE_BITS-1:0] last,
    output logic [PHASE_BITS-1:0] next_idx,
    output logic                  valid
);

    // Scan offsets from N down to 1 so the smallest offset after 'last'
    // wins; offset N is 'last' itself, giving it the lowest priority.
    always_comb begin : pick_search
        int idx;
        idx      = 0;
        next_idx = last;
        valid    = 1'b0;
        for (int k = N_PHASES; k >= 1; k--) begin
            idx = (int'(last) + k) % N_PHASES;
            if (pend[idx]) begin
                next_idx = PHASE_BITS'(idx);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phase_scheduler.sv
// Intersection phase scheduler: shares a single green right-of-way
// between N approaches by round-robin, enforcing min/max green, yellow
// and all-red clearance intervals. Timing advances only on 'tick'.
// Ports:
//   clk            in   1             system clock
//   rst            in   1             synchronous reset, active-high
//   tick           in   1             1 Hz single-cycle enable
//   req            in   N_PHASES      car-sensor level per approach
//   active_phase   out  PHASE_BITS    phase owning right-of-way
//   phase_gry      out  3*N_PHASES    lamps, approach i at [3i+2:3i]
//   current_count  out  COUNT_BITS    ticks remaining in current interval
//   in_clearance   out  1             high in YELLOW or ALL_RED
module phase_scheduler
    import phase_scheduler_pkg::*;
#(
    parameter int N_PHASES    = 4,
    parameter int PHASE_BITS  = 2,
    parameter int COUNT_BITS  = 8,
    parameter int T_MIN_GREEN = 5,
    parameter int T_MAX_GREEN = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [N_PHASES-1:0]     req,
    output logic [PHASE_BITS-1:0]   active_phase,
    output logic [3*N_PHASES-1:0]   phase_gry,
    output logic [COUNT_BITS-1:0]   current_count,
    output logic                    in_clearance
);

    localparam logic [COUNT_BITS-1:0] C_MAX     = COUNT_BITS'(T_MAX_GREEN);
    localparam logic [COUNT_BITS-1:0] C_YELLOW  = COUNT_BITS'(T_YELLOW);
    localparam logic [COUNT_BITS-1:0] C_ALL_RED = COUNT_BITS'(T_ALL_RED);
    localparam logic [COUNT_BITS-1:0] C_ONE     = COUNT_BITS'(1);
    localparam logic [COUNT_BITS:0]   E_MIN     = (COUNT_BITS+1)'(T_MIN_GREEN);
    localparam logic [COUNT_BITS:0]   E_MAX     = (COUNT_BITS+1)'(T_MAX_GREEN);

    state_t                  state_reg;
    logic [PHASE_BITS-1:0]   active_phase_reg;
    logic [N_PHASES-1:0]     pending_reg;
    logic [COUNT_BITS-1:0]   elapsed_reg;
    logic [COUNT_BITS-1:0]   count_reg;
    logic [3*N_PHASES-1:0]   gry_reg;
    logic                    clr_reg;

    logic [N_PHASES-1:0]     active_onehot;
    logic [N_PHASES-1:0]     next_onehot;
    logic [N_PHASES-1:0]     cand;
    logic [N_PHASES-1:0]     pending_next;
    logic [PHASE_BITS-1:0]   pick_idx;
    logic [PHASE_BITS-1:0]   next_phase;
    logic                    pick_valid;
    logic                    other;
    logic                    req_active;
    logic                    state_legal;
    logic                    enter_green;
    logic                    go_yellow;
    logic [COUNT_BITS:0]     e1;
    logic [COUNT_BITS-1:0]   e_sat;

    // Lamp word for a given state and owning phase; all others red.
    function automatic logic [3*N_PHASES-1:0] lamp_word(input state_t s,
                                                        input logic [PHASE_BITS-1:0] p);
        logic [3*N_PHASES-1:0] w;
        w = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            w[3*i +: 3] = LAMP_RED;
            if (p == PHASE_BITS'(i)) begin
                if (s == ST_GREEN)
                    w[3*i +: 3] = LAMP_GREEN;
                else if (s == ST_YELLOW)
                    w[3*i +: 3] = LAMP_YELLOW;
            end
        end
        return w;
    endfunction

    generate
        for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_onehot
            assign active_onehot[gi] = (active_phase_reg == PHASE_BITS'(gi));
            assign next_onehot[gi]   = (next_phase == PHASE_BITS'(gi));
        end
    endgenerate

    // Same-cycle requests count alongside latched ones.
    assign cand        = pending_reg | req;
    assign other       = |(cand & ~active_onehot);
    assign req_active  = |(req & active_onehot);
    assign state_legal = (state_reg == ST_GREEN) || (state_reg == ST_YELLOW) ||
                         (state_reg == ST_ALL_RED);

    rr_picker #(
        .N_PHASES   (N_PHASES),
        .PHASE_BITS (PHASE_BITS)
    ) u_picker (
        .pend     (cand),
        .last     (active_phase_reg),
        .next_idx (pick_idx),
        .valid    (pick_valid)
    );

    assign next_phase  = pick_valid ? pick_idx : active_phase_reg;
    assign enter_green = tick && (state_reg == ST_ALL_RED) && !(count_reg > C_ONE);

    assign e1        = {1'b0, elapsed_reg} + 1'b1;
    assign e_sat     = (e1 >= E_MAX) ? C_MAX : e1[COUNT_BITS-1:0];
    assign go_yellow = other && (e1 >= E_MIN) && (!req_active || (e1 >= E_MAX));

    // The green phase's own sensor is ignored while it is green; the
    // phase being granted green drops its pending bit on that edge.
    always_comb begin
        pending_next = pending_reg |
                       (req & ~((state_reg == ST_GREEN) ? active_onehot : '0));
        if (enter_green)
            pending_next = pending_next & ~next_onehot;
    end

    always_ff @(posedge clk) begin
        if (rst || !state_legal) begin
            state_reg        <= ST_GREEN;
            active_phase_reg <= '0;
            pending_reg      <= '0;
            elapsed_reg      <= '0;
            count_reg        <= C_MAX;
            gry_reg          <= lamp_word(ST_GREEN, '0);
            clr_reg          <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (tick) begin
                case (state_reg)
                    ST_GREEN: begin
                        if (go_yellow) begin
                            state_reg <= ST_YELLOW;
                            count_reg <= C_YELLOW;
                            gry_reg   <= lamp_word(ST_YELLOW, active_phase_reg);
                            clr_reg   <= 1'b1;
                        end else begin
                            // With nobody waiting, rests here with count at 0.
                            elapsed_reg <= e_sat;
                            count_reg   <= C_MAX - e_sat;
                        end
                    end
                    ST_YELLOW: begin
                        if (count_reg > C_ONE) begin
                            count_reg <= count_reg - 1'b1;
                        end else begin
                            state_reg <= ST_ALL_RED;
                            count_reg <= C_ALL_RED;
                            gry_reg   <= lamp_word(ST_ALL_RED, active_phase_reg);
                        end
                    end
                    ST_ALL_RED: begin
                        if (count_reg > C_ONE) begin
                            count_reg <= count_reg - 1'b1;
                        end else begin
                            state_reg        <= ST_GREEN;
                            active_phase_reg <= next_phase;
                            elapsed_reg      <= '0;
                            count_reg        <= C_MAX;
                            gry_reg          <= lamp_word(ST_GREEN, next_phase);
                            clr_reg          <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign active_phase  = active_phase_reg;
    assign phase_gry     = gry_reg;
    assign current_count = count_reg;
    assign in_clearance  = clr_reg;

endmodule

// File: tb/tb_phase_scheduler.sv
// Self-checking bench for phase_scheduler (default parameters).
// Directed scenarios check against hand-derived constants; a random
// scenario checks every cycle against a behavioural model.
module tb_phase_scheduler;

    localparam int N    = 4;
    localparam int TMIN = 5;
    localparam int TMAX = 20;
    localparam int TY   = 3;
    localparam int TAR  = 1;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [3:0]  req;
    logic [1:0]  active_phase;
    logic [11:0] phase_gry;
    logic [7:0]  current_count;
    logic        in_clearance;
    logic [22:0] obs;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // behavioural model: 0=green 1=yellow 2=all-red
    int         m_st, m_ph, m_el, m_cnt;
    logic [3:0] m_pend;

    phase_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .req           (req),
        .active_phase  (active_phase),
        .phase_gry     (phase_gry),
        .current_count (current_count),
        .in_clearance  (in_clearance)
    );

    assign obs = {active_phase, phase_gry, current_count, in_clearance};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] lamps(int st, int ph);
        logic [11:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (i == ph && st == 0)      w[3*i +: 3] = 3'b100;
            else if (i == ph && st == 1) w[3*i +: 3] = 3'b001;
            else                         w[3*i +: 3] = 3'b010;
        end
        return w;
    endfunction

    function automatic logic [22:0] expect_out(int st, int ph, int cnt);
        logic [1:0] p;
        logic [7:0] c;
        p = ph[1:0];
        c = cnt[7:0];
        return {p, lamps(st, ph), c, (st != 0)};
    endfunction

    task automatic model_step();
        logic [3:0] np;
        int e1, q, idx;
        bit other, found;
        if (rst) begin
            m_st = 0; m_ph = 0; m_pend = '0; m_el = 0; m_cnt = TMAX;
            return;
        end
        np = m_pend;
        for (int i = 0; i < N; i++)
            if (req[i] && !(m_st == 0 && i == m_ph)) np[i] = 1'b1;
        if (tick) begin
            case (m_st)
                0: begin
                    other = 0;
                    for (int i = 0; i < N; i++)
                        if (i != m_ph && (m_pend[i] || req[i])) other = 1;
                    e1 = m_el + 1;
                    if (other && e1 >= TMIN && (!req[m_ph] || e1 >= TMAX)) begin
                        m_st = 1; m_cnt = TY;
                    end else begin
                        m_el  = (e1 > TMAX) ? TMAX : e1;
                        m_cnt = TMAX - m_el;
                    end
                end
                1: begin
                    if (m_cnt > 1) m_cnt--;
                    else begin m_st = 2; m_cnt = TAR; end
                end
                default: begin
                    if (m_cnt > 1) m_cnt--;
                    else begin
                        q = m_ph; found = 0;
                        for (int k = 1; k <= N; k++) begin
                            idx = (m_ph + k) % N;
                            if (!found && (m_pend[idx] || req[idx])) begin
                                q = idx; found = 1;
                            end
                        end
                        m_st = 0; m_ph = q; m_el = 0; m_cnt = TMAX;
                        np[q] = 1'b0;
                    end
                end
            endcase
        end
        m_pend = np;
    endtask

    // One clock: tick every 4th cycle, model advanced with the same inputs.
    task automatic clk1();
        tick = (cyc % 4 == 3);
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_ticks(int n);
        for (int t = 0; t < n; ) begin
            clk1();
            if (tick) t++;
        end
    endtask

    // Reset released so the following cycle is a non-tick cycle.
    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        clk1();
        clk1();
        while (cyc % 4 != 0) clk1();
        rst = 1'b0;
    endtask

    task automatic pulse(logic [3:0] m);
        req = m;
        clk1();
        req = '0;
    endtask

    task automatic test_reset();
        logic [22:0] e;
        do_reset();
        e = expect_out(0, 0, 20);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_state obs=%h exp=%h", obs, e); end
        else $display("ok reset_state obs=%h", obs);
        run_ticks(30);
        e = expect_out(0, 0, 0);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL rest_green obs=%h exp=%h", obs, e); end
        else $display("ok rest_green obs=%h", obs);
    endtask

    task automatic test_single_request();
        logic [22:0] e;
        do_reset();
        run_ticks(2);
        pulse(4'b0100);
        run_ticks(3);
        e = expect_out(1, 0, 3);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL req2_yellow obs=%h exp=%h", obs, e); end
        else $display("ok req2_yellow obs=%h", obs);
        run_ticks(3);
        e = expect_out(2, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL req2_allred obs=%h exp=%h", obs, e); end
        else $display("ok req2_allred obs=%h", obs);
        run_ticks(1);
        e = expect_out(0, 2, 20);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL req2_green obs=%h exp=%h", obs, e); end
        else $display("ok req2_green obs=%h", obs);
    endtask

    task automatic test_max_green();
        logic [22:0] e;
        do_reset();
        req = 4'b0011;
        run_ticks(19);
        e = expect_out(0, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL max_t19 obs=%h exp=%h", obs, e); end
        else $display("ok max_t19 obs=%h", obs);
        run_ticks(1);
        e = expect_out(1, 0, 3);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL max_yellow obs=%h exp=%h", obs, e); end
        else $display("ok max_yellow obs=%h", obs);
        run_ticks(3);
        e = expect_out(2, 0, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL max_allred obs=%h exp=%h", obs, e); end
        else $display("ok max_allred obs=%h", obs);
        run_ticks(1);
        e = expect_out(0, 1, 20);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL max_next obs=%h exp=%h", obs, e); end
        else $display("ok max_next obs=%h", obs);
        req = '0;
    endtask

    task automatic test_wrap();
        logic [22:0] e;
        do_reset();
        pulse(4'b0100);
        run_ticks(9);
        pulse(4'b1010);
        run_ticks(4);
        e = expect_out(0, 2, 16);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL wrap_min2 obs=%h exp=%h", obs, e); end
        else $display("ok wrap_min2 obs=%h", obs);
        run_ticks(5);
        e = expect_out(0, 3, 20);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL wrap_ph3 obs=%h exp=%h", obs, e); end
        else $display("ok wrap_ph3 obs=%h", obs);
        run_ticks(4);
        e = expect_out(0, 3, 16);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL wrap_min3 obs=%h exp=%h", obs, e); end
        else $display("ok wrap_min3 obs=%h", obs);
        run_ticks(5);
        e = expect_out(0, 1, 20);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL wrap_ph1 obs=%h exp=%h", obs, e); end
        else $display("ok wrap_ph1 obs=%h", obs);
    endtask

    task automatic test_own_req_in_clearance();
        logic [22:0] e;
        do_reset();
        pulse(4'b0010);
        run_ticks(5);
        pulse(4'b0001);
        run_ticks(4);
        e = expect_out(0, 1, 20);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL own_other obs=%h exp=%h", obs, e); end
        else $display("ok own_other obs=%h", obs);
        run_ticks(9);
        e = expect_out(0, 0, 20);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL own_served obs=%h exp=%h", obs, e); end
        else $display("ok own_served obs=%h", obs);
    endtask

    task automatic test_reset_mid_yellow();
        logic [22:0] e;
        do_reset();
        pulse(4'b0010);
        run_ticks(9);
        pulse(4'b0101);
        run_ticks(5);
        e = expect_out(1, 1, 3);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL pre_rst_yellow obs=%h exp=%h", obs, e); end
        else $display("ok pre_rst_yellow obs=%h", obs);
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        e = expect_out(0, 0, 20);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL mid_rst obs=%h exp=%h", obs, e); end
        else $display("ok mid_rst obs=%h", obs);
        run_ticks(8);
        e = expect_out(0, 0, 12);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL rst_pend_clr obs=%h exp=%h", obs, e); end
        else $display("ok rst_pend_clr obs=%h", obs);
    endtask

    task automatic test_random();
        logic [22:0] e;
        logic [3:0]  flip;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            flip = '0;
            for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 11) == 0);
            req = req ^ flip;
            rst = ($urandom_range(0, 499) == 0);
            clk1();
            e = expect_out(m_st, m_ph, m_cnt);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL random cyc=%0d req=%b obs=%h exp=%h", cyc, req, obs, e);
            end else if (tick) begin
                $display("ok random cyc=%0d req=%b ph=%0d cnt=%0d", cyc, req, active_phase, current_count);
            end
        end
        rst = 1'b0;
        req = '0;
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        req  = '0;
        @(negedge clk);
        test_reset();
        test_single_request();
        test_max_green();
        test_wrap();
        test_own_req_in_clearance();
        test_reset_mid_yellow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
